// File: rtl/vga_grid_renderer.sv
// Battleship board pixel generator: cell-status memory, clear sweeper and a 2-stage colour pipeline.
// Optional macro VGA_GRID_PTR_BLINK_EN blinks the pointer from a frame counter.
module vga_grid_renderer #(
  parameter int          GRID_COLS   = 10,
  parameter int          GRID_ROWS   = 10,
  parameter int          CELL_W_LOG2 = 6,
  parameter int          CELL_H_LOG2 = 5,
  parameter int          LINE_W      = 2,
  parameter int          IDX_W       = 4,
  parameter int          PTR_R       = 5,
  parameter int          BLINK_LOG2  = 4,
  parameter logic [11:0] COL_BG      = 12'h56D,
  parameter logic [11:0] COL_LINE    = 12'hF0F,
  parameter logic [11:0] COL_SHIP    = 12'h555,
  parameter logic [11:0] COL_HIT     = 12'hF80,
  parameter logic [11:0] COL_MISS    = 12'h00F,
  parameter logic [11:0] COL_PTR     = 12'hF00
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable,
  input  logic [9:0]       current_row,
  input  logic [9:0]       current_line,
  input  logic [9:0]       x_pos,
  input  logic [9:0]       y_pos,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_x,
  input  logic [IDX_W-1:0] wr_y,
  input  logic [1:0]       wr_status,
  input  logic             clear_req,
  output logic             busy,
  output logic [11:0]      color_out
);

  localparam int CELLS  = GRID_COLS * GRID_ROWS;
  localparam int ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int COL_W  = 10 - CELL_W_LOG2;
  localparam int ROW_W  = 10 - CELL_H_LOG2;
  localparam int unsigned NCOLS = GRID_COLS;
  localparam int unsigned NROWS = GRID_ROWS;
  localparam int unsigned NLINE = LINE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic signed [10:0] PTR_R11  = 11'(PTR_R);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_IDLE  = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_sweep_addr;

  // Reset parks in ST_START so the first clock after release kicks off the auto-clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= ST_START;
      r_sweep_addr <= '0;
    end else begin
      case (r_state)
        ST_START: begin
          r_state      <= ST_SWEEP;
          r_sweep_addr <= '0;
        end
        ST_SWEEP: begin
          if (r_sweep_addr == LAST_ADDR) begin
            r_state      <= ST_IDLE;
            r_sweep_addr <= '0;
          end else begin
            r_sweep_addr <= r_sweep_addr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            r_state      <= ST_SWEEP;
            r_sweep_addr <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_SWEEP);

  // Write port: the sweeper owns the memory while busy, game writes otherwise.
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [1:0]        w_mem_data;

  assign w_wr_ok    = wr_en && (32'(wr_x) < NCOLS) && (32'(wr_y) < NROWS);
  assign w_wr_addr  = ADDR_W'(32'(wr_y) * NCOLS + 32'(wr_x));
  assign w_mem_we   = busy || w_wr_ok;
  assign w_mem_addr = busy ? r_sweep_addr : w_wr_addr;
  assign w_mem_data = busy ? 2'b00 : wr_status;

  // Stage 1 combinational decode of the current pixel.
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic              w_in_grid;
  logic              w_line;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic              w_ptr_hit;
  logic              w_ptr_vis;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_col     = current_row[9:CELL_W_LOG2];
  assign w_row     = current_line[9:CELL_H_LOG2];
  assign w_in_grid = (32'(w_col) < NCOLS) && (32'(w_row) < NROWS);
  assign w_line    = w_in_grid &&
                     (((32'(current_row[CELL_W_LOG2-1:0]) < NLINE) && (w_col != '0)) ||
                      ((32'(current_line[CELL_H_LOG2-1:0]) < NLINE) && (w_row != '0)));

  // Zero-extended 11-bit signed differences: no wrap at the screen edges.
  assign w_dx      = $signed({1'b0, current_row})  - $signed({1'b0, x_pos});
  assign w_dy      = $signed({1'b0, current_line}) - $signed({1'b0, y_pos});
  assign w_ptr_hit = (w_dx >= -PTR_R11) && (w_dx <= PTR_R11) &&
                     (w_dy >= -PTR_R11) && (w_dy <= PTR_R11);

  // Off-grid pixels read cell 0; the result is masked by in_grid later.
  assign w_rd_addr = w_in_grid ? ADDR_W'(32'(w_row) * NCOLS + 32'(w_col)) : '0;

`ifdef VGA_GRID_PTR_BLINK_EN
  logic [BLINK_LOG2:0] r_frame_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_frame_cnt <= '0;
    end else if (enable && (current_row == '0) && (current_line == '0)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_ptr_vis = ~r_frame_cnt[BLINK_LOG2];
`else
  assign w_ptr_vis = 1'b1;
`endif

  // Board memory is deliberately unreset; the auto-clear initialises it.
  logic [1:0] r_mem [CELLS];
  logic [1:0] r_s1_cell;

  always_ff @(posedge clk_in) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
    r_s1_cell <= r_mem[w_rd_addr];
  end

  logic r_s1_en;
  logic r_s1_in_grid;
  logic r_s1_line;
  logic r_s1_ptr;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_en      <= 1'b0;
      r_s1_in_grid <= 1'b0;
      r_s1_line    <= 1'b0;
      r_s1_ptr     <= 1'b0;
    end else begin
      r_s1_en      <= enable;
      r_s1_in_grid <= w_in_grid;
      r_s1_line    <= w_line;
      r_s1_ptr     <= w_ptr_hit && w_ptr_vis;
    end
  end

  // Stage 2: layer priority pointer > line > cell status > background.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      color_out <= 12'h000;
    end else if (!r_s1_en) begin
      color_out <= 12'h000;
    end else if (r_s1_ptr) begin
      color_out <= COL_PTR;
    end else if (r_s1_line) begin
      color_out <= COL_LINE;
    end else if (r_s1_in_grid) begin
      case (r_s1_cell)
        2'b01:   color_out <= COL_SHIP;
        2'b10:   color_out <= COL_HIT;
        2'b11:   color_out <= COL_MISS;
        default: color_out <= COL_BG;
      endcase
    end else begin
      color_out <= COL_BG;
    end
  end

endmodule

// File: tb/tb_vga_grid_renderer.sv
// Directed + randomized bench for vga_grid_renderer against a behavioural board/colour model.
module tb_vga_grid_renderer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable = 1'b0;
  logic [9:0]  current_row = '0, current_line = '0, x_pos = '0, y_pos = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_x = '0, wr_y = '0;
  logic [1:0]  wr_status = '0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic [11:0] color_out;

  int checks = 0;
  int failures = 0;
  int cells [100];
  bit model_busy = 1'b0;

  vga_grid_renderer dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable(enable),
    .current_row(current_row), .current_line(current_line),
    .x_pos(x_pos), .y_pos(y_pos),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_status(wr_status),
    .clear_req(clear_req), .busy(busy), .color_out(color_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Colour of one pixel from the board rules, using plain arithmetic.
  function automatic logic [11:0] model(input int x, input int y, input bit en,
                                        input int px, input int py);
    int col, row, dx, dy;
    bit ing;
    if (!en) return 12'h000;
    dx = x - px; if (dx < 0) dx = -dx;
    dy = y - py; if (dy < 0) dy = -dy;
    if (dx <= 5 && dy <= 5) return 12'hF00;
    col = x / 64;
    row = y / 32;
    ing = (col < 10) && (row < 10);
    if (ing && (((x % 64) < 2 && col != 0) || ((y % 32) < 2 && row != 0))) return 12'hF0F;
    if (ing) begin
      case (cells[row*10 + col])
        1: return 12'h555;
        2: return 12'hF80;
        3: return 12'h00F;
        default: return 12'h56D;
      endcase
    end
    return 12'h56D;
  endfunction

  task automatic drive_pix(input int x, input int y, input bit en);
    current_row  = 10'(x);
    current_line = 10'(y);
    enable       = en;
  endtask

  task automatic pix_check(input string tag, input int x, input int y, input bit en);
    logic [11:0] e;
    drive_pix(x, y, en);
    e = model(x, y, en, int'(x_pos), int'(y_pos));
    repeat (2) @(posedge clk_in);
    #1;
    chk(tag, color_out, e);
  endtask

  task automatic write_cell(input int x, input int y, input int s);
    bit accept;
    wr_x = 4'(x); wr_y = 4'(y); wr_status = 2'(s); wr_en = 1'b1;
    accept = !model_busy && x < 10 && y < 10;
    @(posedge clk_in); #1;
    wr_en = 1'b0;
    if (accept) cells[y*10 + x] = s;
  endtask

  // One pixel per clock; each result is checked two clocks after it was presented.
  task automatic stream(input string tag, input int mode, input int n);
    logic [11:0] q[$];
    int x, y, px, py;
    bit en;
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) chk(tag, color_out, q.pop_front());
      if (i < n) begin
        if (mode == 0) begin
          x = (i % 10) * 64 + 32; y = ((i / 10) % 10) * 32 + 16;
          en = 1'b1; px = 1000; py = 1000;
        end else begin
          x  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 660));
          y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 340));
          en = ($urandom_range(0, 7) != 0);
          px = x + int'($urandom_range(0, 16)) - 8;
          py = y + int'($urandom_range(0, 16)) - 8;
          if (px < 0) px = 0; if (px > 1023) px = 1023;
          if (py < 0) py = 0; if (py > 1023) py = 1023;
        end
        drive_pix(x, y, en);
        x_pos = 10'(px); y_pos = 10'(py);
        q.push_back(model(x, y, en, px, py));
      end
      @(posedge clk_in); #1;
    end
  endtask

  // Counts cycles with busy high until it drops, bounded.
  task automatic count_busy(inout int n);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_in); #1;
      if (busy) n++;
      else break;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 100; i++) cells[i] = 0;

    // Reset state
    #12;
    chk("rst_color", color_out, 12'h000);
    chk("rst_busy", 12'(busy), 12'h001 & 12'h000);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Auto-clear after reset release
    @(posedge clk_in); #1;
    chk("auto_busy_start", 12'(busy), 12'd1);
    n = busy ? 1 : 0;
    count_busy(n);
    chk("auto_busy_len", 12'(n), 12'd100);
    chk("auto_busy_end", 12'(busy), 12'd0);
    stream("scan_after_reset", 0, 100);

    // Directed writes and pixels
    x_pos = 10'd1000; y_pos = 10'd1000;
    write_cell(3, 2, 1);
    write_cell(4, 2, 2);
    write_cell(10, 0, 3);
    pix_check("ship_200_80", 200, 80, 1'b1);
    pix_check("hit_260_80", 260, 80, 1'b1);
    pix_check("oob_write_alias", 32, 48, 1'b1);
    pix_check("line_64_10", 64, 10, 1'b1);
    pix_check("bg_0_10", 0, 10, 1'b1);
    pix_check("bg_outside_700_10", 700, 10, 1'b1);
    pix_check("line_row_100_32", 100, 32, 1'b1);
    pix_check("disabled", 200, 80, 1'b0);

    // Pointer
    x_pos = 10'd2; y_pos = 10'd2;
    pix_check("ptr_0_0", 0, 0, 1'b1);
    pix_check("ptr_7_7", 7, 7, 1'b1);
    pix_check("ptr_edge_8_0", 8, 0, 1'b1);
    x_pos = 10'd64; y_pos = 10'd10;
    pix_check("ptr_over_line", 64, 10, 1'b1);
    x_pos = 10'd1000; y_pos = 10'd1000;

    // Read-before-write on the same cell in one cycle
    drive_pix(6*64 + 32, 6*32 + 16, 1'b1);
    wr_x = 4'd6; wr_y = 4'd6; wr_status = 2'd3; wr_en = 1'b1;
    @(posedge clk_in); #1;
    wr_en = 1'b0;
    @(posedge clk_in); #1;
    chk("rbw_old", color_out, 12'h56D);
    cells[66] = 3;
    pix_check("rbw_new", 6*64 + 32, 6*32 + 16, 1'b1);

    // Pointer stays red across many frames (blink disabled)
    x_pos = 10'd2; y_pos = 10'd2;
    for (int f = 0; f < 34; f++) pix_check("ptr_frames", 0, 0, 1'b1);
    x_pos = 10'd1000; y_pos = 10'd1000;

    // Random board and random pixel stream
    for (int i = 0; i < 60; i++)
      write_cell(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), int'($urandom_range(0, 3)));
    stream("rand_pixels", 1, 1500);

    // Requested clear with clear_req and wr_en during the sweep
    clear_req = 1'b1;
    @(posedge clk_in); #1;
    clear_req = 1'b0;
    chk("clr_busy_start", 12'(busy), 12'd1);
    model_busy = 1'b1;
    for (int i = 0; i < 100; i++) cells[i] = 0;
    n = busy ? 1 : 0;
    for (int i = 0; i < 49; i++) begin
      @(posedge clk_in); #1;
      if (busy) n++;
    end
    clear_req = 1'b1;
    write_cell(5, 5, 3);
    clear_req = 1'b0;
    if (busy) n++;
    count_busy(n);
    chk("clr_busy_len", 12'(n), 12'd100);
    model_busy = 1'b0;
    stream("scan_after_clear", 0, 100);
    write_cell(5, 5, 3);
    pix_check("write_after_clear", 5*64 + 32, 5*32 + 16, 1'b1);

    // Reset mid-sweep aborts; a fresh auto-clear follows
    clear_req = 1'b1;
    @(posedge clk_in); #1;
    clear_req = 1'b0;
    repeat (20) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    chk("midrst_busy", 12'(busy), 12'd0);
    chk("midrst_color", color_out, 12'h000);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    for (int i = 0; i < 100; i++) cells[i] = 0;
    n = 0;
    count_busy(n);
    chk("midrst_auto_len", 12'(n), 12'd100);
    stream("scan_after_midrst", 0, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_grid_renderer.md
Name: vga_grid_renderer

Overview:
- Parametrised pixel-colour generator for the battleship board; sits between the VGA timing generator and the DAC pins.
- Owns an internal board-state memory (one 2-bit status per cell), a write port driven by game logic, and an auto/requested clear sweeper.
- Composites pointer, grid lines, cell contents and background through a 2-stage registered pipeline.

Parameters:
- GRID_COLS, 10, number of cell columns.
- GRID_ROWS, 10, number of cell rows.
- CELL_W_LOG2, 6, log2 of cell width in pixels (64).
- CELL_H_LOG2, 5, log2 of cell height in pixels (32).
- LINE_W, 2, grid-line thickness in pixels.
- IDX_W, 4, width of cell coordinate ports.
- PTR_R, 5, pointer half-size in pixels.
- BLINK_LOG2, 4, frame-counter bit used for blinking.
- COL_BG, 12'h56D, background colour.
- COL_LINE, 12'hF0F, grid-line colour.
- COL_SHIP, 12'h555, ship cell colour.
- COL_HIT, 12'hF80, hit cell colour.
- COL_MISS, 12'h00F, miss cell colour.
- COL_PTR, 12'hF00, pointer colour.

Ports:
- clk_in  in  1  pixel clock.
- rst_in  in  1  asynchronous, active-high reset.
- enable  in  1  visible-area flag from the timing generator.
- current_row  in  10  pixel x coordinate.
- current_line  in  10  pixel y coordinate.
- x_pos  in  10  pointer centre x.
- y_pos  in  10  pointer centre y.
- wr_en  in  1  cell write strobe.
- wr_x  in  IDX_W  cell column to write.
- wr_y  in  IDX_W  cell row to write.
- wr_status  in  2  status to write: 00 empty, 01 ship, 10 hit, 11 miss.
- clear_req  in  1  single-cycle request to clear the board.
- busy  out  1  clear sweep in progress.
- color_out  out  12  RGB444 pixel colour.

Behaviour:
- Reset (async): color_out=12'h000, busy=0, pipeline valid=0, frame counter=0, sweep counter=0.
- Memory is not reset. On the first clock after rst_in deasserts, busy goes to 1 and an automatic clear starts.
- Clear sweep:
  - Writes 00 to address 0..GRID_COLS*GRID_ROWS-1, one cell per cycle.
  - busy drops in the cycle after the last write, so a sweep takes GRID_COLS*GRID_ROWS cycles.
  - clear_req is accepted only when busy=0; busy goes high the next cycle. clear_req while busy is ignored.
  - wr_en while busy is ignored.
  - rst_in asserted mid-sweep aborts the sweep; a fresh auto-clear runs after release.
- Writes:
  - When busy=0 and wr_en=1 with wr_x<GRID_COLS and wr_y<GRID_ROWS, the cell at wr_y*GRID_COLS+wr_x takes wr_status at the clock edge. Out-of-range writes are dropped.
  - A write and a read of the same cell in the same cycle returns the old value (read-before-write).
- Pipeline stage 1 (registered):
  - col = current_row>>CELL_W_LOG2, row = current_line>>CELL_H_LOG2.
  - in_grid = col<GRID_COLS && row<GRID_ROWS.
  - line flag = in_grid && ((low CELL_W_LOG2 bits of current_row < LINE_W && col!=0) || (low CELL_H_LOG2 bits of current_line < LINE_W && row!=0)).
  - ptr flag = |current_row-x_pos|<=PTR_R && |current_line-y_pos|<=PTR_R, computed in 11-bit signed with no wrap at the screen edges.
  - Synchronous memory read at the computed address; enable is delayed alongside.
- Pipeline stage 2 (registered color_out):
  - Delayed enable=0 gives black.
  - Otherwise priority is: pointer (if visible) > line > cell status (01 ship, 10 hit, 11 miss, in_grid only) > COL_BG.
- Latency: color_out reflects the inputs of exactly 2 clocks earlier. Throughput is 1 pixel/clock.
- Frame counter: increments when enable=1, current_row=0 and current_line=0. Width is BLINK_LOG2+1, wrapping.

Optional Feature:
- Macro VGA_GRID_PTR_BLINK_EN.
- When defined: the pointer is visible only while frame_counter[BLINK_LOG2]==0; otherwise the pixel falls through to the lower-priority layers.
- When undefined: the pointer is always visible and the frame counter is not instantiated.

Test Plan:
- Reset release -> busy=1 for exactly 100 cycles, then 0. A full-frame scan shows no ship/hit/miss colours.
- Idle; write (3,2)=01 then (4,2)=10 -> pixel (200,80) gives 12'h555 and (260,80) gives 12'hF80, each 2 clocks after the coordinate is presented.
- Pixel (64,10) -> 12'hF0F. Pixel (0,10) -> 12'h56D. Pixel (700,10), outside the grid -> 12'h56D. With enable=0 -> 12'h000 after 2 clocks.
- x_pos=2, y_pos=2 -> pixels (0,0) and (7,7) give 12'hF00, (8,0) does not; pointer over a grid line shows 12'hF00.
- clear_req mid-busy plus wr_en during the sweep -> no restart, write dropped. After the sweep, all cells read empty.
- With VGA_GRID_PTR_BLINK_EN: pointer pixel alternates red/background every 16 frames. Without it: red every frame.
